// File: rtl/data_ram_pkg.sv
// Shared constants and the core-to-MMIO write payload for data_ram.
package data_ram_pkg;

    localparam int unsigned DR_ADDR_WIDTH = 32;
    localparam int unsigned DR_DATA_WIDTH = 32;
    localparam int unsigned DR_ZERO       = 0;
    localparam logic [31:0] DR_MMIO_BASE  = 32'hFFFF_FF00;

    // MMIO window is 256 bytes; registers are decoded on word offsets addr[7:2].
    localparam int unsigned MMIO_BYTE_W = 8;
    localparam int unsigned MMIO_WORD_W = 6;

    localparam logic [MMIO_WORD_W-1:0] OFF_CYCLE_LO  = 6'h00;
    localparam logic [MMIO_WORD_W-1:0] OFF_CYCLE_HI  = 6'h01;
    localparam logic [MMIO_WORD_W-1:0] OFF_TOHOST    = 6'h02;
    localparam logic [MMIO_WORD_W-1:0] OFF_SCRATCH   = 6'h03;
    localparam logic [MMIO_WORD_W-1:0] OFF_SNAP_CTRL = 6'h04;
    localparam logic [MMIO_WORD_W-1:0] OFF_SNAP_LO   = 6'h05;
    localparam logic [MMIO_WORD_W-1:0] OFF_SNAP_HI   = 6'h06;

    // Write request presented to the MMIO register block.
    typedef struct packed {
        logic [MMIO_WORD_W-1:0]   off;
        logic [DR_DATA_WIDTH-1:0] data;
        logic                     we;
    } mmio_wr_t;

endpackage

// File: rtl/data_ram_mmio.sv
// MMIO register block: free-running cycle counter, snapshot, scratch, tohost.
module data_ram_mmio
    import data_ram_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  mmio_wr_t                 wr_i,
    input  logic [MMIO_WORD_W-1:0]   rd_off_i,
    output logic [DR_DATA_WIDTH-1:0] rdata_c_o,
    output logic [DR_DATA_WIDTH-1:0] tohost_o,
    output logic                     tohost_valid_o
);

    logic [63:0]              cnt_q, cnt_d;
    logic [63:0]              snap_q, snap_d;
    logic [DR_DATA_WIDTH-1:0] scratch_q, scratch_d;
    logic [DR_DATA_WIDTH-1:0] tohost_q, tohost_d;
    logic                     tohost_valid_q, tohost_valid_d;

    // Next-state: counter always advances; a write updates at most one register.
    always_comb begin
        cnt_d          = cnt_q + 64'd1;
        snap_d         = snap_q;
        scratch_d      = scratch_q;
        tohost_d       = tohost_q;
        tohost_valid_d = 1'b0;
        if (wr_i.we) begin
            case (wr_i.off)
                OFF_TOHOST: begin
                    tohost_d       = wr_i.data;
                    tohost_valid_d = 1'b1;
                end
                OFF_SCRATCH:   scratch_d = wr_i.data;
                OFF_SNAP_CTRL: snap_d    = cnt_q;
                default: ;
            endcase
        end
    end

    // Register state; reset clears everything immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q          <= '0;
            snap_q         <= '0;
            scratch_q      <= '0;
            tohost_q       <= '0;
            tohost_valid_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            snap_q         <= snap_d;
            scratch_q      <= scratch_d;
            tohost_q       <= tohost_d;
            tohost_valid_q <= tohost_valid_d;
        end
    end

    // Combinational read mux; unmapped offsets read as zero.
    always_comb begin
        rdata_c_o = '0;
        case (rd_off_i)
            OFF_CYCLE_LO: rdata_c_o = cnt_q[31:0];
            OFF_CYCLE_HI: rdata_c_o = cnt_q[63:32];
            OFF_TOHOST:   rdata_c_o = tohost_q;
            OFF_SCRATCH:  rdata_c_o = scratch_q;
            OFF_SNAP_LO:  rdata_c_o = snap_q[31:0];
            OFF_SNAP_HI:  rdata_c_o = snap_q[63:32];
            default:      rdata_c_o = '0;
        endcase
    end

    assign tohost_o       = tohost_q;
    assign tohost_valid_o = tohost_valid_q;

endmodule

// File: rtl/data_ram.sv
// Data-side memory: word RAM with preload port plus a small MMIO window.
module data_ram
    import data_ram_pkg::*;
#(
    parameter int unsigned            DEPTH_WORDS = 1024,
    parameter int unsigned            ADDR_WIDTH  = DR_ADDR_WIDTH,
    parameter int unsigned            DATA_WIDTH  = DR_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0]  MMIO_BASE   = ADDR_WIDTH'(DR_MMIO_BASE)
)
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] ram_addr_i,
    input  logic [DATA_WIDTH-1:0] ram_data_i,
    input  logic                  ram_w_request_i,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    input  logic                  load_we_i,
    input  logic [ADDR_WIDTH-1:0] load_addr_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    output logic [DATA_WIDTH-1:0] tohost_o,
    output logic                  tohost_valid_o,
    output logic                  collision_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
    logic [IDX_W-1:0]      ram_idx_c;
    logic [IDX_W-1:0]      load_idx_c;
    logic                  is_mmio_c;
    logic                  core_we_c;
    logic                  collision_q, collision_d;
    mmio_wr_t              mmio_wr_c;
    logic [DATA_WIDTH-1:0] mmio_rdata_c;
    logic                  unused_addr_bits;

    // Address decode; lane bits and bits above the RAM index are don't-care.
    assign ram_idx_c  = ram_addr_i[IDX_W+1:2];
    assign load_idx_c = load_addr_i[IDX_W+1:2];
    assign is_mmio_c  = (ram_addr_i[ADDR_WIDTH-1:MMIO_BYTE_W] == MMIO_BASE[ADDR_WIDTH-1:MMIO_BYTE_W]);
    assign unused_addr_bits = ^{ram_addr_i[1:0], load_addr_i[1:0], load_addr_i[ADDR_WIDTH-1:IDX_W+2]};

    // A preload in the same cycle drops the core write, whatever its address.
    assign core_we_c = ram_w_request_i & ~load_we_i;

    assign mmio_wr_c.off  = ram_addr_i[MMIO_BYTE_W-1:2];
    assign mmio_wr_c.data = ram_data_i;
    assign mmio_wr_c.we   = core_we_c & is_mmio_c;

    data_ram_mmio u_mmio (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .wr_i           (mmio_wr_c),
        .rd_off_i       (ram_addr_i[MMIO_BYTE_W-1:2]),
        .rdata_c_o      (mmio_rdata_c),
        .tohost_o       (tohost_o),
        .tohost_valid_o (tohost_valid_o)
    );

    // RAM array write: not reset, writes blocked while reset is held.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (load_we_i) begin
                mem_q[load_idx_c] <= load_data_i;
            end else if (core_we_c && !is_mmio_c) begin
                mem_q[ram_idx_c] <= ram_data_i;
            end
        end
    end

    // Sticky collision flag, cleared only by reset.
    always_comb begin
        collision_d = collision_q | (load_we_i & ram_w_request_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= collision_d;
        end
    end

    // Zero-latency read path.
    assign ram_data_o  = is_mmio_c ? mmio_rdata_c : mem_q[ram_idx_c];
    assign collision_o = collision_q;

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram: directed corners, vector table, random RAM traffic.
`timescale 1ns/1ps
module tb_data_ram;

    localparam logic [31:0] MB = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_wreq;
    logic        load_we;
    logic [31:0] load_addr, load_data;
    logic [31:0] tohost;
    logic        tohost_valid, collision;

    int checks   = 0;
    int failures = 0;

    bit [31:0]   mdl [int];
    logic [31:0] wr_hist [$];
    logic [31:0] scr_m;

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] rexp;
    } vec_t;
    vec_t tbl [9];

    always #50 clk = ~clk;

    data_ram dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .ram_addr_i      (ram_addr),
        .ram_data_i      (ram_wdata),
        .ram_w_request_i (ram_wreq),
        .ram_data_o      (ram_rdata),
        .load_we_i       (load_we),
        .load_addr_i     (load_addr),
        .load_data_i     (load_data),
        .tohost_o        (tohost),
        .tohost_valid_o  (tohost_valid),
        .collision_o     (collision)
    );

    function automatic int ridx(logic [31:0] a);
        return int'((a >> 2) & 32'd1023);
    endfunction

    function automatic bit is_mmio(logic [31:0] a);
        return a[31:8] == 24'hFF_FFFF;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, expv);
        end
    endtask

    task automatic rd_chk(string name, logic [31:0] a, logic [31:0] expv);
        ram_addr = a;
        #1;
        chk(name, ram_rdata, expv);
    endtask

    task automatic ram_chk(string name, logic [31:0] a);
        ram_addr = a;
        #1;
        if (mdl.exists(ridx(a))) chk(name, ram_rdata, mdl[ridx(a)]);
    endtask

    // One clock edge; the reference memory follows the preload-wins rule.
    task automatic cycle();
        logic        r, lw, we;
        logic [31:0] la, ld, a, d;
        r = rst; lw = load_we; la = load_addr; ld = load_data;
        we = ram_wreq; a = ram_addr; d = ram_wdata;
        @(posedge clk);
        #1;
        if (!r) begin
            if (lw) mdl[ridx(la)] = ld;
            else if (we && !is_mmio(a)) mdl[ridx(a)] = d;
        end
        load_we  = 1'b0;
        ram_wreq = 1'b0;
    endtask

    task automatic core_wr(logic [31:0] a, logic [31:0] d);
        ram_addr = a; ram_wdata = d; ram_wreq = 1'b1;
        cycle();
    endtask

    task automatic preload(logic [31:0] a, logic [31:0] d);
        load_addr = a; load_data = d; load_we = 1'b1;
        cycle();
    endtask

    initial begin
        logic [31:0] a, d, ra;
        int r;

        tbl[0] = '{MB + 32'h0C, 32'h0000_55AA, MB + 32'h0C, 32'h0000_55AA};
        tbl[1] = '{MB + 32'h10, 32'h0000_1234, MB + 32'h10, 32'h0};
        tbl[2] = '{MB + 32'h04, 32'h0000_FFFF, MB + 32'h04, 32'h0};
        tbl[3] = '{MB + 32'h40, 32'h0000_0077, MB + 32'h40, 32'h0};
        tbl[4] = '{MB + 32'h0E, 32'h0000_0009, MB + 32'h0C, 32'h0000_0009};
        tbl[5] = '{MB + 32'h08, 32'h0000_C0DE, MB + 32'h0A, 32'h0000_C0DE};
        tbl[6] = '{32'h0000_0400, 32'hCAFE_F00D, 32'h0001_0400, 32'hCAFE_F00D};
        tbl[7] = '{32'h0000_0FFC, 32'h0BAD_F00D, 32'h7FFF_EFFC, 32'h0BAD_F00D};
        tbl[8] = '{32'hFFFF_FE00, 32'h1357_9BDF, 32'h0000_0E00, 32'h1357_9BDF};

        rst = 1'b1; ram_addr = '0; ram_wdata = '0; ram_wreq = 1'b0;
        load_we = 1'b0; load_addr = '0; load_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tohost", tohost, 32'h0);
        chk("rst_valid", 32'(tohost_valid), 32'h0);
        chk("rst_collision", 32'(collision), 32'h0);
        rd_chk("rst_cycle_lo", MB, 32'h0);

        // Counter starts at zero after release; snapshot after 10 edges.
        rst = 1'b0;
        rd_chk("cycle_first", MB, 32'h0);
        repeat (10) cycle();
        rd_chk("cycle_10", MB, 32'd10);
        core_wr(MB + 32'h10, 32'hFFFF_FFFF);
        rd_chk("snap_lo", MB + 32'h14, 32'd10);
        rd_chk("snap_hi", MB + 32'h18, 32'h0);
        rd_chk("snap_ctrl_rd", MB + 32'h10, 32'h0);
        rd_chk("cycle_11", MB, 32'd11);

        // Preload is visible with zero latency; lane bits ignored.
        preload(32'h100, 32'hDEAD_BEEF);
        rd_chk("preload_100", 32'h100, 32'hDEAD_BEEF);
        rd_chk("preload_102", 32'h102, 32'hDEAD_BEEF);

        // Core write: old data in the write cycle, new data afterwards.
        preload(32'h200, 32'h1111_1111);
        ram_wdata = 32'h1234_5678; ram_wreq = 1'b1;
        rd_chk("wr_same_cycle", 32'h200, 32'h1111_1111);
        cycle();
        rd_chk("wr_next_cycle", 32'h200, 32'h1234_5678);
        rd_chk("wr_alias_1200", 32'h1200, 32'h1234_5678);

        // Tohost single and back-to-back writes.
        core_wr(MB + 32'h08, 32'h0000_00A5);
        chk("th_val", tohost, 32'hA5);
        chk("th_valid_1", 32'(tohost_valid), 32'h1);
        cycle();
        chk("th_valid_0", 32'(tohost_valid), 32'h0);
        chk("th_hold", tohost, 32'hA5);
        core_wr(MB + 32'h08, 32'h1);
        chk("th_b2b_v1", 32'(tohost_valid), 32'h1);
        chk("th_b2b_d1", tohost, 32'h1);
        core_wr(MB + 32'h08, 32'h2);
        chk("th_b2b_v2", 32'(tohost_valid), 32'h1);
        chk("th_b2b_d2", tohost, 32'h2);
        cycle();
        chk("th_b2b_end", 32'(tohost_valid), 32'h0);
        rd_chk("th_read", MB + 32'h08, 32'h2);

        // Vector table: write then read back through the decode.
        for (int i = 0; i < 9; i++) begin
            core_wr(tbl[i].waddr, tbl[i].wdata);
            rd_chk($sformatf("tbl%0d", i), tbl[i].raddr, tbl[i].rexp);
        end

        // Low-word carry into the high word, seen through CYCLE and SNAP.
        force dut.u_mmio.cnt_q = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.u_mmio.cnt_q;
        rd_chk("carry_lo_pre", MB, 32'hFFFF_FFFF);
        rd_chk("carry_hi_pre", MB + 32'h04, 32'h0);
        cycle();
        rd_chk("carry_hi", MB + 32'h04, 32'h1);
        rd_chk("carry_lo", MB, 32'h0);
        core_wr(MB + 32'h10, 32'h0);
        rd_chk("snap_hi_carry", MB + 32'h18, 32'h1);
        rd_chk("snap_lo_carry", MB + 32'h14, 32'h0);

        // Preload and core write collide: preload wins, flag is sticky.
        preload(32'h304, 32'h0000_0304);
        chk("coll_before", 32'(collision), 32'h0);
        load_addr = 32'h300; load_data = 32'hAAAA_0000; load_we = 1'b1;
        ram_addr = 32'h304; ram_wdata = 32'hBBBB_0000; ram_wreq = 1'b1;
        cycle();
        rd_chk("coll_preload", 32'h300, 32'hAAAA_0000);
        rd_chk("coll_dropped", 32'h304, 32'h0000_0304);
        chk("coll_set", 32'(collision), 32'h1);
        repeat (3) cycle();
        chk("coll_sticky", 32'(collision), 32'h1);

        // Random RAM traffic with aliased reads, plus scratch traffic.
        scr_m = 32'h0BEE_F00D;
        core_wr(MB + 32'h0C, scr_m);
        wr_hist.push_back(32'h100);
        for (int it = 0; it < 400; it++) begin
            r = int'($urandom_range(0, 9));
            ra = wr_hist[$urandom_range(0, wr_hist.size() - 1)] ^ ($urandom & 32'h7FFF_F003);
            ram_chk("rnd_read", ra);
            a = $urandom & 32'h7FFF_FFFF;
            d = $urandom;
            if (r < 3) begin
                load_addr = $urandom;
                load_data = $urandom;
                load_we   = 1'b1;
                wr_hist.push_back(load_addr & 32'h7FFF_FFFF);
            end
            if (r >= 2 && r < 7) begin
                ram_addr = a; ram_wdata = d; ram_wreq = 1'b1;
                wr_hist.push_back(a);
                ram_chk("rnd_old", a);
            end else if (r == 7) begin
                d = $urandom;
                ram_addr = MB + 32'h0C; ram_wdata = d; ram_wreq = 1'b1;
                scr_m = d;
            end else if (r == 8) begin
                rd_chk("rnd_scratch", MB + 32'h0C, scr_m);
            end
            cycle();
        end
        chk("coll_after_rnd", 32'(collision), 32'h1);

        // Reset mid-cycle: registers clear at once, RAM is kept, writes ignored.
        core_wr(MB + 32'h0C, 32'h0000_55AA);
        rd_chk("scr_55aa", MB + 32'h0C, 32'h0000_55AA);
        core_wr(MB + 32'h08, 32'h33);
        chk("th_33", tohost, 32'h33);
        #20;
        rst = 1'b1;
        #1;
        chk("mrst_tohost", tohost, 32'h0);
        chk("mrst_valid", 32'(tohost_valid), 32'h0);
        chk("mrst_collision", 32'(collision), 32'h0);
        rd_chk("mrst_scratch", MB + 32'h0C, 32'h0);
        rd_chk("mrst_cycle_lo", MB, 32'h0);
        rd_chk("mrst_cycle_hi", MB + 32'h04, 32'h0);
        rd_chk("mrst_snap_hi", MB + 32'h18, 32'h0);
        core_wr(32'h100, 32'h0000_0999);
        preload(32'h104, 32'h0000_0888);
        core_wr(MB + 32'h0C, 32'h0000_7777);
        core_wr(MB + 32'h08, 32'h0000_4444);
        rst = 1'b0;
        ram_chk("rst_keep_100", 32'h100);
        ram_chk("rst_keep_104", 32'h104);
        ram_chk("rst_keep_300", 32'h300);
        ram_chk("rst_keep_200", 32'h200);
        rd_chk("rst_scr_blocked", MB + 32'h0C, 32'h0);
        chk("rst_th_blocked", tohost, 32'h0);
        chk("rst_coll_clear", 32'(collision), 32'h0);
        for (int k = 0; k < 20; k++) begin
            ram_chk("rst_keep_rnd", wr_hist[$urandom_range(0, wr_hist.size() - 1)]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_ram.md
Name: data_ram

Overview:
- Data-side memory for the single-issue RV32 core; sits directly downstream of the mem stage.
- Consumes the mem stage's word address, merged write word and write request.
- Returns the addressed word combinationally, so byte/half stores complete their read-modify-write merge in one cycle.
- Hosts a small MMIO window: cycle counter, counter snapshot, scratch and tohost. Also exposes a testbench preload port.

Parameters:
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two.
- ADDR_WIDTH, 32: byte address width (matches `ADDR_WIDTH).
- DATA_WIDTH, 32: data word width (matches `DATA_WIDTH).
- MMIO_BASE, 32'hFFFF_FF00: base of the 256-byte MMIO window.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  asynchronous reset, active-high.
- ram_addr_i  in  ADDR_WIDTH  byte address from the mem stage.
- ram_data_i  in  DATA_WIDTH  full merged write word from the mem stage.
- ram_w_request_i  in  1  write strobe from the mem stage.
- ram_data_o  out  DATA_WIDTH  read word for ram_addr_i; combinational.
- load_we_i  in  1  preload write strobe.
- load_addr_i  in  ADDR_WIDTH  preload byte address.
- load_data_i  in  DATA_WIDTH  preload word.
- tohost_o  out  DATA_WIDTH  last value written to TOHOST.
- tohost_valid_o  out  1  one-cycle pulse per TOHOST write.
- collision_o  out  1  sticky: preload and core write hit the same cycle.

Behaviour:
- Decode: MMIO when addr[31:8]==MMIO_BASE[31:8]; otherwise RAM.
  - RAM index = addr[log2(DEPTH_WORDS)+1:2]; higher bits are ignored, so addresses alias and wrap modulo DEPTH_WORDS*4.
  - addr[1:0] is ignored; alignment and lane merging are the mem stage's job.
- Read: ram_data_o is a purely combinational function of ram_addr_i and current state.
  - No read latency.
  - Reads of unmapped MMIO offsets return 0.
- RAM write: on posedge clk_i, when ram_w_request_i=1 and the address decodes to RAM, mem[index] <= ram_data_i as a full word.
  - The new data is visible on ram_data_o from the following cycle; the same cycle shows the old data.
- Preload: on posedge clk_i, when load_we_i=1, mem[load index] <= load_data_i. load_addr_i is always treated as a RAM address.
  - If load_we_i and ram_w_request_i are both 1 in the same cycle, the preload wins, the core write is dropped, and collision_o is set to 1 until reset. This holds regardless of address.
- MMIO offsets (byte offset from MMIO_BASE):
  - 0x00 CYCLE_LO: read-only, low 32 bits of the free-running 64-bit counter.
  - 0x04 CYCLE_HI: read-only, high 32 bits of the counter.
  - 0x08 TOHOST: write sets tohost_o <= data and pulses tohost_valid_o high for exactly the next cycle. Reads return tohost_o.
  - 0x0C SCRATCH: read/write, 32 bits.
  - 0x10 SNAP_CTRL: any write captures the full 64-bit counter value of that same edge into SNAP_LO/SNAP_HI atomically. Reads return 0.
  - 0x14 SNAP_LO, 0x18 SNAP_HI: read-only.
  - All other offsets: writes ignored, reads return 0.
- Counter:
  - 0 while rst_i=1.
  - Increments by 1 on every posedge after reset deasserts, so the first cycle after reset reads 0.
  - Wraps from 2^64-1 to 0 with no flag.
  - CYCLE_HI and CYCLE_LO reads are not atomic; software uses SNAP.
- Reset (asynchronous, immediate on rst_i rising):
  - Outputs: tohost_o=0, tohost_valid_o=0, collision_o=0.
  - Registers: SCRATCH=0, SNAP=0, counter=0.
  - The RAM array is not cleared; contents persist across reset.
  - All writes are ignored while rst_i=1.
  - A write whose edge coincides with reset assertion is lost.
- Back-to-back TOHOST writes on consecutive cycles give a continuous valid high, with tohost_o updating each cycle.
- The HALT_ADDR store is detected by the mem stage. This block treats it as an ordinary RAM/MMIO access per the decode above.

Decomposition:
- Shared defines: MMIO_BASE default and the offsets CYCLE_LO/CYCLE_HI/TOHOST/SCRATCH/SNAP_CTRL/SNAP_LO/SNAP_HI.
- ADDR_WIDTH/DATA_WIDTH/ZERO reuse the existing defines.
- One sub-module: data_ram_mmio. It holds the counter, snapshot, scratch and tohost registers, with its own decode and read mux.
- The top level holds the array, RAM/MMIO select and preload arbitration.

Test Plan:
- Preload 0x100<=0xDEADBEEF, then drive ram_addr_i=0x100 -> ram_data_o=0xDEADBEEF the same cycle. Addr 0x102 also -> 0xDEADBEEF.
- Core write 0x200<=0x12345678 at edge N -> ram_data_o=old value during cycle N, 0x12345678 from N+1. Addr 0x1200 (DEPTH 1024) aliases -> 0x12345678.
- Write 0xA5 to MMIO_BASE+0x08 -> tohost_o=0xA5 and tohost_valid_o=1 for exactly one cycle, then 0. Two consecutive writes -> valid high for 2 cycles.
- Release reset, wait 10 edges, write SNAP_CTRL -> SNAP_LO=10, SNAP_HI=0. Force the counter to 0xFFFF_FFFF low word -> the next snapshot shows HI=1, LO=0.
- Assert load_we_i and ram_w_request_i together on different addresses -> only the preload address changes, and collision_o=1 until the next rst_i.
- Write SCRATCH=0x55AA, assert rst_i mid-cycle -> SCRATCH, counter and tohost_o are 0 immediately. Previously written RAM word is unchanged. A write attempted while rst_i=1 has no effect.
